// File: rtl/axi_tg_pkg.sv
// Shared types, AXI constants and pattern/boundary helpers for the AXI memory traffic generator.
package axi_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } tg_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Widest AXI data bus; callers truncate to their own DATA_WIDTH.
    localparam int unsigned PAT_MAX_WIDTH = 1024;
    localparam int unsigned PAGE_BYTES    = 4096;

    function automatic logic [PAT_MAX_WIDTH-1:0] pattern_beat(input logic [31:0] seed,
                                                              input logic [8:0]  idx);
        logic [31:0] word;
        word = seed + 32'(idx);
        return {(PAT_MAX_WIDTH/32){word}};
    endfunction

    function automatic logic crosses_4k(input logic [63:0]   addr,
                                        input logic [8:0]    len,
                                        input int unsigned   bytes_per_beat);
        logic [31:0] end_off;
        end_off = 32'(addr[11:0]) + 32'(len) * bytes_per_beat;
        return end_off > 32'(PAGE_BYTES);
    endfunction

endpackage

// File: rtl/axi4.sv
// Minimal AXI4 interface (AW/W/B/AR/R) shared between the traffic generator and a memory slave.
interface axi4 #(
    parameter int unsigned ADDR_WIDTH = 48,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input  rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_tg_checker.sv
// R-channel comparator: counts read beats, compares against the pattern, tracks RRESP/RLAST errors.
module axi_tg_checker
    import axi_tg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  rvalid,
    input  logic                  rready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic [31:0]           seed,
    input  logic [8:0]            burst_len,
    output logic [CNT_WIDTH-1:0]  mismatch_cnt,
    output logic                  rresp_err,
    output logic                  last_err,
    output logic                  final_beat_c
);
    logic [8:0] beat;
    logic       hs_c;
    logic       is_final_c;

    assign hs_c         = rvalid && rready;
    assign is_final_c   = (beat == burst_len - 9'd1);
    assign final_beat_c = hs_c && is_final_c;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            beat         <= '0;
            mismatch_cnt <= '0;
            rresp_err    <= 1'b0;
            last_err     <= 1'b0;
        end else if (hs_c) begin
            beat <= beat + 9'd1;
            if ((rdata != DATA_WIDTH'(pattern_beat(seed, beat))) && (mismatch_cnt != '1))
                mismatch_cnt <= mismatch_cnt + CNT_WIDTH'(1);
            if (rresp != AXI_RESP_OKAY)
                rresp_err <= 1'b1;
            // Early RLAST and missing RLAST are both reported; the beat count alone ends the read.
            if (rlast != is_final_c)
                last_err <= 1'b1;
        end
    end
endmodule

// File: rtl/axi_mem_traffic_gen.sv
// AXI4 master that writes one INCR burst of a seeded pattern, reads it back and reports the result.
module axi_mem_traffic_gen
    import axi_tg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 48,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [8:0]            burst_len,
    input  logic [31:0]           seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_WIDTH-1:0]  mismatch_cnt,
    output logic                  bresp_err,
    output logic                  rresp_err,
    output logic                  last_err,
    output logic                  cfg_err,
    axi4.master                   axi_port
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned SIZE  = $clog2(BYTES);

    tg_state_t             state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [8:0]            len_q;
    logic [31:0]           seed_q;
    logic [8:0]            beat;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready;
    logic                  start_ok_c, cfg_bad_c, rd_done_c;

    assign start_ok_c = (state == ST_IDLE) && start;
    assign cfg_bad_c  = (burst_len == 9'd0) || (burst_len > 9'd256) ||
                        (base_addr[SIZE-1:0] != '0) ||
                        crosses_4k(64'(base_addr), burst_len, BYTES);

    // Fixed burst attributes; payloads only change while their VALID is low.
    assign axi_port.awid    = '0;
    assign axi_port.awaddr  = base_q;
    assign axi_port.awlen   = 8'(len_q - 9'd1);
    assign axi_port.awsize  = 3'(SIZE);
    assign axi_port.awburst = AXI_BURST_INCR;
    assign axi_port.awvalid = aw_valid;
    assign axi_port.wdata   = w_data;
    assign axi_port.wstrb   = '1;
    assign axi_port.wlast   = w_last;
    assign axi_port.wvalid  = w_valid;
    assign axi_port.bready  = b_ready;
    assign axi_port.arid    = '0;
    assign axi_port.araddr  = base_q;
    assign axi_port.arlen   = 8'(len_q - 9'd1);
    assign axi_port.arsize  = 3'(SIZE);
    assign axi_port.arburst = AXI_BURST_INCR;
    assign axi_port.arvalid = ar_valid;
    assign axi_port.rready  = r_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            bresp_err <= 1'b0;
            cfg_err   <= 1'b0;
            aw_valid  <= 1'b0;
            w_valid   <= 1'b0;
            w_last    <= 1'b0;
            b_ready   <= 1'b0;
            ar_valid  <= 1'b0;
            r_ready   <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            seed_q    <= '0;
            beat      <= '0;
            w_data    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    base_q    <= base_addr;
                    len_q     <= burst_len;
                    seed_q    <= seed;
                    busy      <= 1'b1;
                    pass      <= 1'b0;
                    bresp_err <= 1'b0;
                    beat      <= '0;
                    if (cfg_bad_c) begin
                        cfg_err <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        cfg_err  <= 1'b0;
                        aw_valid <= 1'b1;
                        state    <= ST_AW;
                    end
                end
                ST_AW: if (axi_port.awready) begin
                    aw_valid <= 1'b0;
                    w_valid  <= 1'b1;
                    w_data   <= DATA_WIDTH'(pattern_beat(seed_q, 9'd0));
                    w_last   <= (len_q == 9'd1);
                    state    <= ST_W;
                end
                ST_W: if (axi_port.wready) begin
                    if (w_last) begin
                        w_valid <= 1'b0;
                        w_last  <= 1'b0;
                        b_ready <= 1'b1;
                        state   <= ST_B;
                    end else begin
                        beat   <= beat + 9'd1;
                        w_data <= DATA_WIDTH'(pattern_beat(seed_q, beat + 9'd1));
                        w_last <= (beat + 9'd2 == len_q);
                    end
                end
                ST_B: if (axi_port.bvalid) begin
                    b_ready   <= 1'b0;
                    bresp_err <= (axi_port.bresp != AXI_RESP_OKAY);
                    ar_valid  <= 1'b1;
                    state     <= ST_AR;
                end
                ST_AR: if (axi_port.arready) begin
                    ar_valid <= 1'b0;
                    r_ready  <= 1'b1;
                    state    <= ST_R;
                end
                ST_R: if (rd_done_c) begin
                    r_ready <= 1'b0;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (mismatch_cnt == '0) && !bresp_err && !rresp_err &&
                             !last_err && !cfg_err;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axi_tg_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_checker (
        .clk          (clk),
        .rst          (rst),
        .clear        (start_ok_c),
        .rvalid       (axi_port.rvalid),
        .rready       (r_ready),
        .rdata        (axi_port.rdata),
        .rresp        (axi_port.rresp),
        .rlast        (axi_port.rlast),
        .seed         (seed_q),
        .burst_len    (len_q),
        .mismatch_cnt (mismatch_cnt),
        .rresp_err    (rresp_err),
        .last_err     (last_err),
        .final_beat_c (rd_done_c)
    );
endmodule

// File: doc/axi_mem_traffic_gen.md
Name: axi_mem_traffic_gen

Overview:
- AXI4 master stimulus/check stage in sim_src/test_utility. Drives one INCR write burst of a deterministic pattern into a downstream AXI4 memory slave, then reads the same burst back and compares it beat by beat.
- Produces pass/fail status, a mismatch count and response-error flags.
- Feeds the block-RAM AXI slave directly over the shared axi4 interface.

Parameters:
- ADDR_WIDTH, 48, AXI address width.
- DATA_WIDTH, 64, AXI data width; must be a multiple of 32.
- CNT_WIDTH, 16, width of the saturating mismatch counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse starting a test; ignored unless the state is IDLE.
- base_addr  input  ADDR_WIDTH  burst start address; sampled on start.
- burst_len  input  9  number of beats, 1..256; sampled on start.
- seed  input  32  pattern seed; sampled on start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at the end of a test.
- pass  output  1  result of the last test; valid from done until the next accepted start.
- mismatch_cnt  output  CNT_WIDTH  count of mismatched read beats; saturates at all-ones.
- bresp_err  output  1  BRESP was not OKAY.
- rresp_err  output  1  any RRESP was not OKAY.
- last_err  output  1  RLAST was not aligned with the final beat.
- cfg_err  output  1  illegal configuration; the test is aborted.
- axi_port  axi4.master  -  AW/W/B/AR/R channels to the slave.

Behaviour:
- Reset (synchronous, active-high; takes priority over everything):
  - State returns to IDLE.
  - All VALID/READY outputs, busy, done, pass, status flags and mismatch_cnt go to 0.
  - If reset occurs mid-burst, valids drop immediately and the slave may be left mid-transaction. The bench must reset both sides together.
- Fixed AXI fields:
  - AWSIZE/ARSIZE = log2(DATA_WIDTH/8).
  - AWBURST/ARBURST = INCR (2'b01).
  - IDs = 0; WSTRB = all ones.
  - AWLEN/ARLEN = burst_len-1.
  - Address = the latched base_addr.
- Pattern: beat i data = the 32-bit word (seed+i) mod 2^32, replicated DATA_WIDTH/32 times.
- State machine IDLE -> AW -> W -> B -> AR -> R -> DONE -> IDLE.
  - IDLE: on start, latch inputs and clear flags, mismatch_cnt and pass.
    - cfg_err=1 if burst_len is 0 or >256, base_addr is not aligned to DATA_WIDTH/8, or the burst crosses a 4 KB boundary.
    - With cfg_err=1, go straight to DONE; no AXI traffic is issued.
    - Otherwise go to AW.
  - AW: AWVALID=1 on the first cycle after start; hold it until AWREADY; then go to W.
  - W:
    - WVALID held high, with no idle gaps; the beat counter advances on WVALID&&WREADY.
    - WLAST=1 only on beat burst_len-1.
    - After the last handshake, go to B.
    - Write data is never presented before the AW handshake.
  - B: BREADY=1; on BVALID, set bresp_err if BRESP!=0, then go to AR.
  - AR: ARVALID held until ARREADY, then go to R.
  - R:
    - RREADY=1.
    - Each RVALID&&RREADY compares RDATA with the expected beat. A mismatch increments mismatch_cnt (saturating).
    - RRESP!=0 sets rresp_err.
    - last_err is set if RLAST=1 on a beat other than the final one, or RLAST=0 on the final beat.
    - The read completes after burst_len beats regardless of RLAST. Beats after an early RLAST are still counted.
  - DONE:
    - Assert done for one cycle.
    - pass = no mismatches and no flags set.
    - busy=0; return to IDLE.
- Latency: with an always-ready slave, the write data phase takes burst_len cycles after the AW handshake.
- Stability: every VALID and its payload stay stable until accepted (AXI rule). VALID never depends combinationally on READY.
- start while busy: ignored; latched values are unaffected.

Decomposition:
- Shared package axi_tg_pkg:
  - State enum.
  - AXI_BURST_INCR and AXI_RESP_OKAY constants.
  - Function pattern_beat(seed, idx) returning DATA_WIDTH bits.
  - Function crosses_4k(addr, len, bytes_per_beat).
- One natural sub-module, axi_tg_checker: R-channel comparator holding the beat counter, mismatch counter and RLAST/RRESP flags. Shares pattern_beat with the writer.

Test Plan:
- base_addr=0x1000, burst_len=16, seed=0xA5A50000, always-ready slave -> 16 W beats, beat 3 = 0xA5A50003A5A50003; done, pass=1, mismatch_cnt=0.
- Same test, with the bench corrupting read beat 5 and beat 9 -> pass=0, mismatch_cnt=2, other flags 0.
- burst_len=1 and burst_len=256 at base_addr=0x0 -> WLAST on the only beat / beat 255; pass=1.
- base_addr=0x0FF8, burst_len=2 (crosses 4 KB) -> cfg_err=1, done within 2 cycles of start, no AWVALID ever asserted.
- Slave returns BRESP=2'b10, and RLAST on beat 2 of 4 -> bresp_err=1, last_err=1, pass=0; start pulse while busy is ignored.
- rst asserted during the W phase at beat 7 of 16 -> next cycle all valids=0, busy=0; a fresh test after reset (slave also reset) passes.
